fp_rnd_pipe: RTL and testbench

//  Pipelined IEEE-754 rounding/packing stage. It is the consumer end of the fp_rnd record that the conversion units emit.
//  - Takes an unrounded {sig,expo,mant,grs,...} record; produces a packed single/double result plus the fflags.
//  - Two register stages; valid/ready handshake both sides. Sits between the fp_cvt/arith units and writeback.

---
 rtl/fp_wire.sv | 48 ++++
 rtl/fp_rnd_core.sv | 48 ++++
 rtl/fp_rnd_pipe.sv | 142 ++++++++++++++
 tb/tb_fp_rnd_pipe.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_wire.sv
// Shared types and constants for the fp rounding/packing path.
package fp_wire;

    // Unrounded record produced by the conversion and arithmetic units
    typedef struct packed {
        logic        sig;
        logic [13:0] expo;
        logic [53:0] mant;
        logic [1:0]  rema;
        logic [1:0]  fmt;
        logic [2:0]  rm;
        logic [2:0]  grs;
        logic        snan;
        logic        qnan;
        logic        dbz;
        logic        inf;
        logic        zero;
    } fp_rnd_in_type;

    // Payload held between the round stage and the pack stage
    typedef struct packed {
        logic        sig;
        logic [13:0] expo;
        logic [51:0] frac;
        logic        dbl;
        logic [2:0]  rm;
        logic        nx;
        logic        snan;
        logic        qnan;
        logic        dbz;
        logic        inf;
        logic        zero;
    } fp_rnd_pipe_reg_type;

    localparam logic [31:0] CanonNanSgl = 32'h7FC0_0000;
    localparam logic [63:0] CanonNanDbl = 64'h7FF8_0000_0000_0000;
    localparam logic [31:0] MaxFinSgl   = 32'h7F7F_FFFF;
    localparam logic [63:0] MaxFinDbl   = 64'h7FEF_FFFF_FFFF_FFFF;
    localparam logic [13:0] ExpoMaxSgl  = 14'd255;
    localparam logic [13:0] ExpoMaxDbl  = 14'd2047;

    localparam logic [2:0] RmRne = 3'd0;
    localparam logic [2:0] RmRtz = 3'd1;
    localparam logic [2:0] RmRdn = 3'd2;
    localparam logic [2:0] RmRup = 3'd3;
    localparam logic [2:0] RmRmm = 3'd4;

endpackage

// File: rtl/fp_rnd_core.sv
// Combinational round-increment and renormalisation of an unrounded significand.
module fp_rnd_core
    import fp_wire::*;
(
    input  logic        sig_i,
    input  logic        dbl_i,
    input  logic [2:0]  rm_i,
    input  logic [2:0]  grs_i,
    input  logic [13:0] expo_i,
    input  logic [53:0] mant_i,
    output logic [13:0] expo_o,
    output logic [51:0] frac_o,
    output logic        nx_o
);

    logic [53:0] mant_src;
    logic [53:0] mant_inc;
    logic [52:0] mant_norm;
    logic        inc;
    logic        carry;
    logic        hidden;

    // Decide the increment, add it, and renormalise on carry-out of the significand
    always_comb begin
        // Single keeps {ovf, hidden, frac} in the low 25 bits only
        mant_src = dbl_i ? mant_i : {29'd0, mant_i[24:0]};
        nx_o     = |grs_i;
        case (rm_i)
            RmRtz:   inc = 1'b0;
            RmRdn:   inc = sig_i & nx_o;
            RmRup:   inc = ~sig_i & nx_o;
            RmRmm:   inc = grs_i[2];
            // RNE, and the reserved codes 5..7 which behave as RNE
            default: inc = grs_i[2] & (mant_src[0] | grs_i[1] | grs_i[0]);
        endcase
        mant_inc  = mant_src + {53'd0, inc};
        carry     = dbl_i ? mant_inc[53] : mant_inc[24];
        mant_norm = carry ? mant_inc[53:1] : mant_inc[52:0];
        expo_o    = carry ? expo_i + 14'd1 : expo_i;
        hidden    = dbl_i ? mant_norm[52] : mant_norm[23];
        // A subnormal that rounds into the hidden bit becomes the smallest normal
        if (expo_o == 14'd0 && hidden) begin
            expo_o = 14'd1;
        end
        frac_o = mant_norm[51:0];
    end

endmodule

// File: rtl/fp_rnd_pipe.sv
// Two-stage IEEE-754 round (stage 1) and pack/specials (stage 2) pipeline.
module fp_rnd_pipe
    import fp_wire::*;
#(
    parameter bit NAN_BOX = 1'b0
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          clear,
    input  logic          in_valid,
    output logic          in_ready,
    input  fp_rnd_in_type fp_rnd_i,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [63:0]   result,
    output logic [4:0]    flags
);

    logic                adv1, adv2;
    logic                v1_q, v1_d, v2_q, v2_d;
    logic                s1_en, s2_en;
    fp_rnd_pipe_reg_type s1_q, s1_d;
    logic [63:0]         res_q, res_d;
    logic [4:0]          flg_q, flg_d;
    logic [13:0]         rnd_expo;
    logic [51:0]         rnd_frac;
    logic                rnd_nx;
    logic                in_dbl;
    logic [13:0]         expo_lim;
    logic                away;
    logic [31:0]         sp;
    logic [63:0]         dp;
    logic                unused_rema;

    assign unused_rema = ^fp_rnd_i.rema;

    assign adv2      = ~v2_q | out_ready;
    assign adv1      = ~v1_q | adv2;
    assign in_ready  = adv1;
    assign out_valid = v2_q;
    assign result    = res_q;
    assign flags     = flg_q;
    assign in_dbl    = (fp_rnd_i.fmt != 2'd0);

    fp_rnd_core u_core (
        .sig_i  (fp_rnd_i.sig),
        .dbl_i  (in_dbl),
        .rm_i   (fp_rnd_i.rm),
        .grs_i  (fp_rnd_i.grs),
        .expo_i (fp_rnd_i.expo),
        .mant_i (fp_rnd_i.mant),
        .expo_o (rnd_expo),
        .frac_o (rnd_frac),
        .nx_o   (rnd_nx)
    );

    // Valid/enable control; clear overrides every transfer
    always_comb begin
        v1_d  = clear ? 1'b0 : (adv1 ? in_valid : v1_q);
        v2_d  = clear ? 1'b0 : (adv2 ? v1_q : v2_q);
        s1_en = ~clear & adv1 & in_valid;
        s2_en = ~clear & adv2 & v1_q;
    end

    // Stage-1 payload from the rounding core
    always_comb begin
        s1_d      = '0;
        s1_d.sig  = fp_rnd_i.sig;
        s1_d.expo = rnd_expo;
        s1_d.frac = rnd_frac;
        s1_d.dbl  = in_dbl;
        s1_d.rm   = fp_rnd_i.rm;
        s1_d.nx   = rnd_nx;
        s1_d.snan = fp_rnd_i.snan;
        s1_d.qnan = fp_rnd_i.qnan;
        s1_d.dbz  = fp_rnd_i.dbz;
        s1_d.inf  = fp_rnd_i.inf;
        s1_d.zero = fp_rnd_i.zero;
    end

    // Stage-2 special-case selection and packing, highest priority first
    always_comb begin
        sp       = '0;
        dp       = '0;
        flg_d    = '0;
        expo_lim = s1_q.dbl ? ExpoMaxDbl : ExpoMaxSgl;
        case (s1_q.rm)
            RmRtz:   away = 1'b0;
            RmRdn:   away = s1_q.sig;
            RmRup:   away = ~s1_q.sig;
            default: away = 1'b1;
        endcase
        if (s1_q.snan) begin
            sp       = CanonNanSgl;
            dp       = CanonNanDbl;
            flg_d[4] = 1'b1;
        end else if (s1_q.qnan) begin
            sp = CanonNanSgl;
            dp = CanonNanDbl;
        end else if (s1_q.inf) begin
            sp       = {s1_q.sig, 8'hFF, 23'd0};
            dp       = {s1_q.sig, 11'h7FF, 52'd0};
            flg_d[3] = s1_q.dbz;
        end else if (s1_q.zero) begin
            sp = {s1_q.sig, 31'd0};
            dp = {s1_q.sig, 63'd0};
        end else if (s1_q.expo >= expo_lim) begin
            sp       = away ? {s1_q.sig, 8'hFF, 23'd0} : {s1_q.sig, MaxFinSgl[30:0]};
            dp       = away ? {s1_q.sig, 11'h7FF, 52'd0} : {s1_q.sig, MaxFinDbl[62:0]};
            flg_d[2] = 1'b1;
            flg_d[0] = 1'b1;
        end else begin
            sp       = {s1_q.sig, s1_q.expo[7:0], s1_q.frac[22:0]};
            dp       = {s1_q.sig, s1_q.expo[10:0], s1_q.frac};
            flg_d[1] = s1_q.nx & (s1_q.expo == 14'd0);
            flg_d[0] = s1_q.nx;
        end
        res_d = s1_q.dbl ? dp : {(NAN_BOX ? 32'hFFFF_FFFF : 32'd0), sp};
    end

    // Pipeline state; output registers hold while stalled
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            v1_q  <= 1'b0;
            v2_q  <= 1'b0;
            s1_q  <= '0;
            res_q <= '0;
            flg_q <= '0;
        end else begin
            v1_q <= v1_d;
            v2_q <= v2_d;
            if (s1_en) begin
                s1_q <= s1_d;
            end
            if (s2_en) begin
                res_q <= res_d;
                flg_q <= flg_d;
            end
        end
    end

endmodule

// File: tb/tb_fp_rnd_pipe.sv
// Bench for fp_rnd_pipe: directed cases plus a randomised stream against a value-level model.
module tb_fp_rnd_pipe;
    import fp_wire::*;

    logic          clock = 1'b0;
    logic          reset;
    logic          clear;
    logic          in_valid;
    logic          in_ready;
    fp_rnd_in_type rec;
    logic          out_valid;
    logic          out_ready;
    logic [63:0]   result;
    logic [4:0]    flags;

    int            checks = 0;
    int            errors = 0;
    logic [68:0]   q[$];
    bit            stalled = 0;
    logic [63:0]   held_res;
    logic [4:0]    held_flg;

    fp_rnd_pipe #(.NAN_BOX(1'b0)) dut (
        .clock     (clock),
        .reset     (reset),
        .clear     (clear),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .fp_rnd_i  (rec),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .flags     (flags)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Value-level model: returns {result, flags}
    function automatic logic [68:0] ref_model(input fp_rnd_in_type r);
        bit              dbl, up, away, nx;
        int              w, mode;
        longint unsigned emax, e, m, frac_mask, sign_bit, res;
        logic [4:0]      fl;
        dbl       = (r.fmt != 2'd0);
        w         = dbl ? 52 : 23;
        emax      = dbl ? 2047 : 255;
        frac_mask = (64'd1 << w) - 1;
        m         = 64'(r.mant) & ((64'd1 << (w + 2)) - 1);
        e         = 64'(r.expo);
        nx        = (r.grs != 3'd0);
        mode      = (r.rm > 3'd4) ? 0 : int'(r.rm);
        case (mode)
            0:       up = r.grs[2] && (((m & 1) != 0) || r.grs[1] || r.grs[0]);
            1:       up = 0;
            2:       up = r.sig && nx;
            3:       up = !r.sig && nx;
            default: up = r.grs[2];
        endcase
        m = m + 64'(up);
        if ((m >> (w + 1)) != 0) begin
            m = m >> 1;
            e = e + 1;
        end
        if (e == 0 && ((m >> w) & 1) != 0) e = 1;
        away     = (mode == 0) || (mode == 4) || (mode == 3 && !r.sig) || (mode == 2 && r.sig);
        sign_bit = dbl ? (64'(r.sig) << 63) : (64'(r.sig) << 31);
        fl       = 5'b00000;
        if (r.snan) begin
            res = dbl ? 64'h7FF8_0000_0000_0000 : 64'h7FC0_0000;
            fl  = 5'b10000;
        end else if (r.qnan) begin
            res = dbl ? 64'h7FF8_0000_0000_0000 : 64'h7FC0_0000;
        end else if (r.inf) begin
            res   = sign_bit | (emax << w);
            fl[3] = r.dbz;
        end else if (r.zero) begin
            res = sign_bit;
        end else if (e >= emax) begin
            fl  = 5'b00101;
            res = away ? (sign_bit | (emax << w)) : (sign_bit | ((emax - 1) << w) | frac_mask);
        end else begin
            res   = sign_bit | (e << w) | (m & frac_mask);
            fl[0] = nx;
            fl[1] = nx && (e == 0);
        end
        return {res, fl};
    endfunction

    function automatic fp_rnd_in_type mk(input logic [1:0] fmt, input logic sig,
                                         input logic [13:0] expo, input logic [53:0] mant,
                                         input logic [2:0] grs, input logic [2:0] rm);
        fp_rnd_in_type r;
        r      = '0;
        r.fmt  = fmt;
        r.sig  = sig;
        r.expo = expo;
        r.mant = mant;
        r.grs  = grs;
        r.rm   = rm;
        return r;
    endfunction

    function automatic fp_rnd_in_type rand_rec();
        fp_rnd_in_type r;
        logic [63:0]   fr;
        int            k;
        r      = '0;
        r.fmt  = 2'($urandom_range(0, 3));
        r.sig  = 1'($urandom);
        r.rm   = 3'($urandom);
        r.grs  = 3'($urandom);
        r.rema = 2'($urandom);
        fr     = {$urandom, $urandom};
        if (r.fmt != 2'd0) begin
            r.expo = 14'($urandom_range(0, 2049));
            if ($urandom_range(0, 3) == 0) begin
                r.expo = 14'd2046;
                fr     = '1;
            end
            r.mant = {1'b0, (r.expo != 14'd0), fr[51:0]};
        end else begin
            r.expo = 14'($urandom_range(0, 257));
            if ($urandom_range(0, 3) == 0) begin
                r.expo = 14'd254;
                fr     = '1;
            end
            r.mant = {29'd0, 1'b0, (r.expo != 14'd0), fr[22:0]};
        end
        k = $urandom_range(0, 15);
        if (k == 0) begin
            r.snan = 1'b1;
            r.qnan = 1'($urandom);
        end else if (k == 1) begin
            r.qnan = 1'b1;
        end else if (k == 2) begin
            r.inf = 1'b1;
            r.dbz = 1'($urandom);
        end else if (k == 3) begin
            r.zero = 1'b1;
        end
        return r;
    endfunction

    // Single isolated transfer; caller is at posedge+1 with an empty pipeline and out_ready=1
    task automatic send_and_check(input string tag, input fp_rnd_in_type r,
                                  input logic [63:0] er, input logic [4:0] ef);
        int lat;
        rec      = r;
        in_valid = 1'b1;
        @(posedge clock); #1;
        in_valid = 1'b0;
        lat      = 1;
        while (!out_valid && lat < 10) begin
            @(posedge clock); #1;
            lat++;
        end
        chk({tag, "_latency"}, 64'(lat), 64'd2);
        chk({tag, "_result"}, result, er);
        chk({tag, "_flags"}, 64'(flags), 64'(ef));
        @(posedge clock); #1;
    endtask

    // One clock of scoreboarded traffic; inputs are already driven at posedge+1
    task automatic cycle();
        logic [68:0] exp;
        #1;
        chk("in_ready", 64'(in_ready), 64'((q.size() < 2) || out_ready));
        if (q.size() == 0) chk("idle_out_valid", 64'(out_valid), 64'd0);
        if (stalled) begin
            chk("hold_valid", 64'(out_valid), 64'd1);
            chk("hold_result", result, held_res);
            chk("hold_flags", 64'(flags), 64'(held_flg));
        end
        stalled = 0;
        if (clear) begin
            q.delete();
        end else begin
            if (out_valid && out_ready && q.size() > 0) begin
                exp = q.pop_front();
                chk("stream_result", result, exp[68:5]);
                chk("stream_flags", 64'(flags), 64'(exp[4:0]));
            end
            if (in_valid && in_ready) q.push_back(ref_model(rec));
            if (out_valid && !out_ready) begin
                stalled  = 1;
                held_res = result;
                held_flg = flags;
            end
        end
        @(posedge clock); #1;
    endtask

    initial begin
        fp_rnd_in_type r;
        reset     = 1'b1;
        clear     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        rec       = '0;
        #12;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_result", result, 64'd0);
        chk("rst_flags", 64'(flags), 64'd0);
        @(posedge clock); #1;
        reset = 1'b0;
        #1;
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        @(posedge clock); #1;

        send_and_check("one", mk(2'd0, 1'b0, 14'd127, 54'h0800000, 3'b000, RmRne),
                       64'h3F80_0000, 5'b00000);
        send_and_check("carry_rne", mk(2'd0, 1'b0, 14'd127, 54'h0FFFFFF, 3'b110, RmRne),
                       64'h4000_0000, 5'b00001);
        send_and_check("carry_rtz", mk(2'd0, 1'b0, 14'd127, 54'h0FFFFFF, 3'b110, RmRtz),
                       64'h3FFF_FFFF, 5'b00001);
        send_and_check("ovf_rne",
                       mk(2'd1, 1'b0, 14'd2046, 54'h1FFFFFFFFFFFFF, 3'b100, RmRne),
                       64'h7FF0_0000_0000_0000, 5'b00101);
        // RTZ leaves the exponent at 2046: largest finite, inexact but not overflowed
        send_and_check("ovf_rtz",
                       mk(2'd1, 1'b0, 14'd2046, 54'h1FFFFFFFFFFFFF, 3'b100, RmRtz),
                       64'h7FEF_FFFF_FFFF_FFFF, 5'b00001);
        r = mk(2'd0, 1'b0, 14'd0, 54'd0, 3'b000, RmRne);
        r.snan = 1'b1;
        send_and_check("snan", r, 64'h7FC0_0000, 5'b10000);
        r.snan = 1'b0;
        r.qnan = 1'b1;
        send_and_check("qnan", r, 64'h7FC0_0000, 5'b00000);
        r = mk(2'd0, 1'b1, 14'd0, 54'd0, 3'b000, RmRne);
        r.inf = 1'b1;
        r.dbz = 1'b1;
        send_and_check("inf_dbz", r, 64'hFF80_0000, 5'b01000);
        send_and_check("sub_promote", mk(2'd0, 1'b0, 14'd0, 54'h07FFFFF, 3'b100, RmRne),
                       64'h0080_0000, 5'b00001);
        send_and_check("sub_tiny", mk(2'd0, 1'b0, 14'd0, 54'h07FFFFF, 3'b001, RmRtz),
                       64'h007F_FFFF, 5'b00011);

        // Back-to-back stream into a stalled sink
        out_ready = 1'b0;
        in_valid  = 1'b1;
        rec = rand_rec(); cycle();
        rec = rand_rec(); cycle();
        rec = rand_rec();
        #1;
        chk("full_in_ready", 64'(in_ready), 64'd0);
        repeat (3) cycle();
        out_ready = 1'b1;
        cycle();
        in_valid = 1'b0;
        repeat (4) cycle();

        // Asynchronous reset mid-cycle with two records held
        out_ready = 1'b0;
        in_valid  = 1'b1;
        rec = rand_rec(); cycle();
        rec = rand_rec(); cycle();
        in_valid = 1'b0;
        #3;
        reset = 1'b1;
        #1;
        chk("async_rst_out_valid", 64'(out_valid), 64'd0);
        chk("async_rst_result", result, 64'd0);
        q.delete();
        stalled = 0;
        #2;
        reset = 1'b0;
        @(posedge clock); #1;
        out_ready = 1'b1;
        repeat (4) cycle();

        // Clear drops the record in flight and the one offered alongside it
        in_valid = 1'b1;
        rec = rand_rec(); cycle();
        rec = rand_rec();
        clear = 1'b1;
        cycle();
        clear    = 1'b0;
        in_valid = 1'b0;
        repeat (4) cycle();

        // Randomised traffic with random backpressure
        repeat (400) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            rec       = rand_rec();
            cycle();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (4) cycle();
        chk("drain_empty", 64'(q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
